// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port memory between IF fetch and LSU, with starvation guard and flushable fetch responses.
// Optional ARB_PERF_CNT_EN adds o_if_stall_cnt, a saturating count of denied IF request cycles.
module imem_dmem_arbiter #(
  parameter int XLEN       = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [XLEN-1:0]   i_if_addr,
  input  logic              i_if_flush,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [31:0]       o_if_rdata,
  input  logic              i_lsu_req,
  input  logic              i_lsu_we,
  input  logic [XLEN-1:0]   i_lsu_addr,
  input  logic [XLEN-1:0]   i_lsu_wdata,
  input  logic [XLEN/8-1:0] i_lsu_be,
  output logic              o_lsu_gnt,
  output logic              o_lsu_rvalid,
  output logic [XLEN-1:0]   o_lsu_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_be,
  input  logic [XLEN-1:0]   i_mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       o_if_stall_cnt
`endif
);
  logic [3:0]         r_starve;
  logic [MEM_LAT-1:0] r_vld;
  logic [MEM_LAT-1:0] r_own;
  logic               w_if_gnt;
  logic               w_lsu_gnt;
  logic               w_rd;
  logic               w_if_rv;
  logic               w_lsu_rv;
  always_comb begin
    w_if_gnt  = !i_rst && i_if_req && (!i_lsu_req || r_starve == 4'(STARVE_MAX));
    w_lsu_gnt = !i_rst && i_lsu_req && !w_if_gnt;
    w_rd      = w_if_gnt || (w_lsu_gnt && !i_lsu_we);
    // a flush also kills the IF response surfacing this very cycle
    w_if_rv   = !i_rst && r_vld[MEM_LAT-1] && !r_own[MEM_LAT-1] && !i_if_flush;
    w_lsu_rv  = !i_rst && r_vld[MEM_LAT-1] && r_own[MEM_LAT-1];
  end
  assign o_if_gnt     = w_if_gnt;
  assign o_lsu_gnt    = w_lsu_gnt;
  assign o_mem_en     = w_if_gnt || w_lsu_gnt;
  assign o_mem_we     = w_lsu_gnt && i_lsu_we;
  assign o_mem_addr   = w_if_gnt ? i_if_addr : w_lsu_gnt ? i_lsu_addr : '0;
  assign o_mem_wdata  = o_mem_we ? i_lsu_wdata : '0;
  assign o_mem_be     = w_lsu_gnt ? i_lsu_be : w_if_gnt ? '1 : '0;
  assign o_if_rvalid  = w_if_rv;
  assign o_if_rdata   = w_if_rv ? i_mem_rdata[31:0] : '0;
  assign o_lsu_rvalid = w_lsu_rv;
  assign o_lsu_rdata  = w_lsu_rv ? i_mem_rdata : '0;
  // r_own: 1 = LSU, 0 = IF; index 0 is the newest grant
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve <= '0;
      r_vld    <= '0;
      r_own    <= '0;
    end else begin
      r_starve <= (w_if_gnt || !i_if_req) ? 4'd0 : r_starve + 4'd1;
      r_vld[0] <= w_rd;
      r_own[0] <= w_lsu_gnt;
      for (int k = 1; k < MEM_LAT; k++) begin
        r_vld[k] <= r_vld[k-1] && !(i_if_flush && !r_own[k-1]);
        r_own[k] <= r_own[k-1];
      end
    end
  end
`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_stall;
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_stall <= '0;
    else if (i_if_req && !w_if_gnt && r_stall != '1)
      r_stall <= r_stall + 32'd1;
  end
  assign o_if_stall_cnt = r_stall;
`endif
endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port synchronous memory between the IF stage fetch port and the LSU data port.
- Arbitrates one access per cycle with a req/gnt handshake and routes read data back to the owner after a fixed latency.
- Prevents fetch starvation and drops in-flight fetch responses when a branch redirects the PC.
- Sits between if_stage/LSU and the unified instruction/data memory.

Parameters:
- XLEN, 32, address/data width.
- MEM_LAT, 1, memory read latency in cycles (legal 1..4).
- STARVE_MAX, 4, consecutive denied IF cycles before IF is forced priority (legal 1..15).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_if_req  in  1  IF read request; held until granted.
- i_if_addr  in  XLEN  IF fetch address (word aligned).
- i_if_flush  in  1  branch taken; discard older in-flight IF responses.
- o_if_gnt  out  1  IF request accepted this cycle.
- o_if_rvalid  out  1  IF read data valid.
- o_if_rdata  out  32  IF instruction word.
- i_lsu_req  in  1  LSU request; held until granted.
- i_lsu_we  in  1  1 = write, 0 = read.
- i_lsu_addr  in  XLEN  LSU address.
- i_lsu_wdata  in  XLEN  LSU write data.
- i_lsu_be  in  XLEN/8  LSU byte enables.
- o_lsu_gnt  out  1  LSU request accepted this cycle.
- o_lsu_rvalid  out  1  LSU read data valid (reads only).
- o_lsu_rdata  out  XLEN  LSU read data.
- o_mem_en, o_mem_we  out  1  memory enable / write enable.
- o_mem_addr, o_mem_wdata  out  XLEN  memory address / write data.
- o_mem_be  out  XLEN/8  memory byte enables.
- i_mem_rdata  in  XLEN  memory read data, valid MEM_LAT cycles after the enabled read.

Behaviour:
- Grant logic:
  - Grants are combinational from the requests and the starvation state.
  - At most one of o_if_gnt / o_lsu_gnt is high per cycle.
  - A grant is never issued without its request.
- Memory drive: o_mem_* is driven combinationally from the granted requester in the grant cycle. When idle, o_mem_en=0, o_mem_we=0 and the remaining memory outputs are 0.
- Priority:
  - LSU wins by default.
  - A 4-bit starve_cnt increments each cycle i_if_req=1 && o_if_gnt=0, and clears on any IF grant.
  - When starve_cnt==STARVE_MAX, IF wins that cycle even if the LSU is requesting.
- Response tracking:
  - A MEM_LAT-deep shift register of {valid, owner} is pushed every cycle. A push is valid only for a read grant; writes push invalid.
  - At the tail, rvalid is asserted to the owner with rdata = i_mem_rdata.
  - Exactly one rvalid per granted read, MEM_LAT cycles after the grant. Responses return in grant order.
  - The non-owner rdata output is 0.
- Flush:
  - i_if_flush clears the valid bit of every IF-owned entry already in the shift register, i.e. grants from earlier cycles. Their rvalid never appears.
  - An IF grant in the same cycle as the flush is kept.
  - LSU entries are unaffected.
  - starve_cnt is unaffected.
- Reset:
  - All outputs are 0, starve_cnt is 0, and the shift register is cleared.
  - Reset mid-operation discards in-flight responses: no rvalid in the cycles following reset release for pre-reset grants.
  - Requests are ignored while i_rst=1.
- Both idle: no memory access and counters hold, except that starve_cnt clears when i_if_req=0.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - Adds output o_if_stall_cnt[31:0].
  - Counts cycles with i_if_req=1 && o_if_gnt=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by i_rst.
- Undefined: the port and counter are absent. The arbitration behaviour is identical in both cases.

Test Plan:
- IF only, MEM_LAT=1, addrs 0x0, 0x4, 0x8 on consecutive cycles -> o_if_gnt=1 each cycle; o_if_rvalid=1 one cycle later with imem words 0x00000013, 0x00100093, 0x00200113.
- Simultaneous IF + LSU read at 0x10, STARVE_MAX=4 -> LSU granted first; o_lsu_rvalid carries mem[0x10] one cycle later; IF granted next cycle.
- LSU requests every cycle for 10 cycles while IF requests 0x14 -> IF granted on the 5th cycle (starve_cnt==4); starve_cnt returns to 0; LSU resumes.
- IF grants at 0x0 and 0x4 with MEM_LAT=2, i_if_flush=1 in the cycle of grant 0x8 -> rvalid only for 0x8; no response for 0x0/0x4.
- LSU write we=1, be=4'b0011, addr 0x20, wdata 0xDEADBEEF -> o_mem_we=1, o_mem_be=4'b0011 in the grant cycle; no o_lsu_rvalid ever.
- LSU read granted, i_rst=1 in the next cycle -> all outputs 0; no o_lsu_rvalid after reset release. With ARB_PERF_CNT_EN, o_if_stall_cnt=0.
